alpha_calc_pipe: RTL and testbench

ALPHA_CALC_PIPE -- requirements
Module: alpha_calc_pipe

---
 rtl/alpha_calc_pipe.sv | 106 ++++++++++
 tb/tb_alpha_calc_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_calc_pipe.sv
// alpha_calc_pipe: two-stage elastic pipeline quantising dark_diff/denominator into an alpha weight.
// Define ALPHA_CALC_SAT_CNT_EN to add the frame_clr input and the saturating sat_count output.
module alpha_calc_pipe #(
    parameter int DATA_W      = 8,
    parameter int ALPHA_W     = 7,
    parameter int LOG2_LEVELS = 3,
    parameter int ALPHA_SAT   = 125
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    dark_diff,
    input  logic [DATA_W-1:0]    denominator,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ALPHA_W-1:0]   alpha,
    output logic [LOG2_LEVELS:0] level,
`ifdef ALPHA_CALC_SAT_CNT_EN
    input  logic                 frame_clr,
    output logic [31:0]          sat_count,
`endif
    output logic                 out_last
);

    localparam int unsigned LEVELS = 1 << LOG2_LEVELS;
    localparam int          NUM_W  = DATA_W + LOG2_LEVELS + 1;
    localparam int          SHIFT  = ALPHA_W - LOG2_LEVELS;

    logic                    s1_valid;
    logic [DATA_W-1:0]       s1_dd;
    logic [DATA_W-1:0]       s1_den;
    logic                    s1_last;
    logic                    s2_ready;
    logic [NUM_W-1:0]        num;
    logic [NUM_W-1:0]        acc;
    logic [LOG2_LEVELS:0]    k;
    logic [ALPHA_W-1:0]      alpha_next;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dd    <= '0;
            s1_den   <= '0;
            s1_last  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_dd   <= dark_diff;
                s1_den  <= denominator;
                s1_last <= in_last;
            end
        end
    end

    // Count thresholds k*den met by the scaled numerator; a zero denominator meets all of them.
    always_comb begin
        num = NUM_W'(s1_dd) << LOG2_LEVELS;
        acc = '0;
        k   = '0;
        for (int unsigned i = 0; i < LEVELS; i++) begin
            acc = acc + NUM_W'(s1_den);
            if (num >= acc) begin
                k = k + (LOG2_LEVELS + 1)'(1);
            end
        end
        alpha_next = k[LOG2_LEVELS] ? ALPHA_W'(ALPHA_SAT) : (ALPHA_W'(k) << SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alpha     <= '0;
            level     <= '0;
            out_last  <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                alpha    <= alpha_next;
                level    <= k;
                out_last <= s1_last;
            end
        end
    end

`ifdef ALPHA_CALC_SAT_CNT_EN
    logic sat_hit;

    assign sat_hit = out_valid && out_ready && level[LOG2_LEVELS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (frame_clr) begin
            sat_count <= sat_hit ? 32'd1 : 32'd0;
        end else if (sat_hit && (sat_count != '1)) begin
            sat_count <= sat_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alpha_calc_pipe.sv
// Self-checking bench for alpha_calc_pipe: vector table, stall/reset sequences and random traffic.
// The sat_count checks run only when ALPHA_CALC_SAT_CNT_EN is defined.
module tb_alpha_calc_pipe;

    localparam int DW     = 8;
    localparam int AW     = 7;
    localparam int LL     = 3;
    localparam int SAT    = 125;
    localparam int LEVELS = 2 ** LL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dark_diff;
    logic [DW-1:0] denominator;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] alpha;
    logic [LL:0]   level;
    logic          out_last;
`ifdef ALPHA_CALC_SAT_CNT_EN
    logic          frame_clr;
    logic [31:0]   sat_count;
`endif

    always #5 clk = ~clk;

    alpha_calc_pipe #(
        .DATA_W(DW),
        .ALPHA_W(AW),
        .LOG2_LEVELS(LL),
        .ALPHA_SAT(SAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dark_diff(dark_diff),
        .denominator(denominator),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alpha(alpha),
        .level(level),
`ifdef ALPHA_CALC_SAT_CNT_EN
        .frame_clr(frame_clr),
        .sat_count(sat_count),
`endif
        .out_last(out_last)
    );

    typedef struct {
        logic [LL:0]   level;
        logic [AW-1:0] alpha;
        logic          last;
    } exp_t;

    typedef struct {
        int dd;
        int den;
        int level;
        int alpha;
    } vec_t;

    exp_t sbq[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   in_count  = 0;
    int   out_count = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: k = floor(dd*LEVELS/den) capped at LEVELS, den==0 saturates.
    function automatic exp_t model(input int dd, input int den, input logic last);
        exp_t e;
        int   k;
        k = (den == 0) ? LEVELS : (dd * LEVELS) / den;
        if (k > LEVELS) k = LEVELS;
        e.level = (LL + 1)'(k);
        e.alpha = (k == LEVELS) ? AW'(SAT) : AW'(k * (2 ** (AW - LL)));
        e.last  = last;
        return e;
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        exp_t        e;
        logic        stalled;
        logic [AW-1:0] p_alpha;
        logic [LL:0] p_level;
        logic        p_last;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbq.delete();
                stalled = 1'b0;
                continue;
            end
            if (stalled)
                check("stall_hold", {out_valid, alpha, level, out_last}, {1'b1, p_alpha, p_level, p_last});
            if (out_valid && out_ready) begin
                out_count++;
                if (sbq.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("sb_level", level, e.level);
                    check("sb_alpha", alpha, e.alpha);
                    check("sb_last", out_last, e.last);
                end
            end
            if (in_valid && in_ready) begin
                in_count++;
                sbq.push_back(model(int'(dark_diff), int'(denominator), in_last));
            end
            stalled = out_valid && !out_ready;
            p_alpha = alpha;
            p_level = level;
            p_last  = out_last;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_vec(input vec_t v, input logic last);
        int lat;
        @(posedge clk); #1;
        in_valid    = 1'b1;
        dark_diff   = DW'(v.dd);
        denominator = DW'(v.den);
        in_last     = last;
        @(negedge clk);
        check("vec_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 8);
        check("vec_latency", lat, 2);
        check("vec_level", level, v.level);
        check("vec_alpha", alpha, v.alpha);
        check("vec_last", out_last, last);
    endtask

    initial begin
        vec_t tbl[12];
        int   sdd[5];
        int   acc_i;
        int   seen_fall;
        int   in0;
        int   out0;

        tbl[0]  = '{200, 200, 8, 125};
        tbl[1]  = '{100, 200, 4, 64};
        tbl[2]  = '{24,  200, 0, 0};
        tbl[3]  = '{25,  200, 1, 16};
        tbl[4]  = '{0,   0,   8, 125};
        tbl[5]  = '{255, 1,   8, 125};
        tbl[6]  = '{0,   200, 0, 0};
        tbl[7]  = '{199, 200, 7, 112};
        tbl[8]  = '{175, 200, 7, 112};
        tbl[9]  = '{1,   0,   8, 125};
        tbl[10] = '{255, 255, 8, 125};
        tbl[11] = '{50,  255, 1, 16};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        dark_diff   = '0;
        denominator = '0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
`ifdef ALPHA_CALC_SAT_CNT_EN
        frame_clr   = 1'b0;
`endif
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_alpha", alpha, 0);
        check("rst_level", level, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef ALPHA_CALC_SAT_CNT_EN
        check("rst_sat_count", sat_count, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'(i % 2));

        // Stall: out_ready low for four cycles while five samples are offered.
        sdd = '{200, 100, 25, 0, 150};
        acc_i = 0;
        seen_fall = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 60 && acc_i < 5; c++) begin
            out_ready   = (c >= 4);
            in_valid    = 1'b1;
            dark_diff   = DW'(sdd[acc_i]);
            denominator = 8'd200;
            in_last     = 1'(acc_i == 4);
            @(negedge clk);
            if (!in_ready && seen_fall == 0) begin
                seen_fall = 1;
                check("stall_accepted", acc_i, 2);
                check("stall_out_valid", out_valid, 1);
            end
            if (in_ready) acc_i++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_fell", seen_fall, 1);
        for (int c = 0; c < 50 && sbq.size() != 0; c++) @(negedge clk);
        check("stall_drain", sbq.size(), 0);

        // Reset with two samples in flight.
        @(posedge clk); #1;
        in_valid = 1'b1; dark_diff = 8'd200; denominator = 8'd200;
        @(posedge clk); #1;
        dark_diff = 8'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_level", level, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 check("midrst_release_ready", in_ready, 1);
        out0 = out_count;
        run_vec(tbl[3], 1'b1);
        repeat (5) @(negedge clk);
        check("midrst_single_out", out_count - out0, 1);

        // Randomised traffic against the reference model.
        in0  = in_count;
        out0 = out_count;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            dark_diff = DW'($urandom);
            in_last   = 1'($urandom);
            case ($urandom_range(0, 7))
                0:       denominator = '0;
                1:       denominator = 8'd1;
                default: denominator = DW'($urandom);
            endcase
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && sbq.size() != 0; c++) @(negedge clk);
        check("rand_drain", sbq.size(), 0);
        check("rand_count", out_count - out0, in_count - in0);

`ifdef ALPHA_CALC_SAT_CNT_EN
        @(posedge clk); #1 frame_clr = 1'b1;
        @(posedge clk); #1 frame_clr = 1'b0;
        check("sat_clr", sat_count, 0);
        run_vec(tbl[0], 1'b0);
        run_vec(tbl[1], 1'b0);
        run_vec(tbl[4], 1'b0);
        run_vec(tbl[2], 1'b0);
        run_vec(tbl[5], 1'b1);
        @(posedge clk); #1;
        check("sat_count3", sat_count, 3);
        out_ready = 1'b0;
        in_valid = 1'b1; dark_diff = 8'd255; denominator = 8'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
        check("sat_pending", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        frame_clr = 1'b1;
        @(posedge clk); #1;
        frame_clr = 1'b0;
        check("sat_clr_hit", sat_count, 1);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
